transfer_sequencer: RTL
=======================

# transfer_sequencer

Controller between the byte-stream receiver and the key-value balance store. Skips a fixed header, assembles a 12-byte transfer packet (source key, destination key, amount), then sequences the store port through read-source, read-destination, write-debit and write-credit with balance and overflow checks. Reports one status per packet. Sits downstream of the UART/byte deframer and upstream of the single-ported KV store.

## Interface
- HDR_BYTES, 3, accepted bytes discarded before each packet's payload
- PKT_BYTES, 12, payload bytes per packet (fixed; not for override)
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  block can accept a byte; high only in COLLECT
- kv_req  out  1  store request
- kv_op  out  2  1 = read, 2 = write, 0 = none
- kv_kind  out  1  0 = debit side (source), 1 = credit side (destination)
- kv_key  out  32  store key
- kv_value  out  32  write data; 0 on reads
- kv_ack  in  1  request accepted/complete this cycle
- kv_rdata  in  32  read balance, valid with kv_ack on reads
- kv_miss  in  1  key absent, valid with kv_ack on reads
- busy  out  1  high outside COLLECT
- done  out  1  one-cycle pulse, status valid
- status  out  2  0 OK, 1 INSUFFICIENT, 2 MISS, 3 OVERFLOW; held until next done

## Operation
- Byte transfer occurs on a cycle with byte_valid && byte_ready. Counter runs 0..HDR_BYTES+11; first HDR_BYTES bytes dropped; payload bytes big-endian: 0-3 src key, 4-7 dst key, 8-11 amount.
- States: COLLECT, RD_SRC, RD_DST, WR_SRC, WR_DST, DONE.
- COLLECT -> RD_SRC on transfer of last payload byte; counter clears.
- RD_SRC on ack: miss -> DONE/MISS; rdata < amount -> DONE/INSUFFICIENT; src == dst -> DONE/OK (no writes); else latch src balance, -> RD_DST.
- RD_DST on ack: miss -> DONE/MISS; dst balance + amount carries out of 32 bits -> DONE/OVERFLOW; else latch, -> WR_SRC.
- WR_SRC: write src balance − amount, kind 0; on ack -> WR_DST.
- WR_DST: write dst balance + amount, kind 1; on ack -> DONE/OK.
- DONE: done = 1 for one cycle, status updated; -> COLLECT.
- Amount 0 runs the full sequence (writes unchanged balances), status OK.
- Arithmetic: compare unsigned; overflow check uses 33-bit sum.

## Timing
- Reset values: state COLLECT, counter 0, byte_ready 1, kv_req 0, kv_op 0, kv_kind 0, kv_key 0, kv_value 0, busy 0, done 0, status 0.
- kv_* outputs are Moore: decoded from state and registered packet/balances only; kv_req high for the whole of RD_*/WR_* states, op/key/value stable until the ack cycle.
- Ack may arrive in the first request cycle (zero wait) or any later cycle; no timeout. kv_ack outside a request is ignored.
- Zero-wait ack: last payload byte at edge N -> RD_SRC cycle N+1, RD_DST N+2, WR_SRC N+3, WR_DST N+4, done pulse N+5, byte_ready high N+6.
- Bytes offered while busy are not consumed (byte_ready low); the upstream holds them.
- Reset mid-sequence: next edge returns to COLLECT, kv_req low, partial packet discarded; a completed debit is not rolled back (store-side journaling is out of scope).

## Structure
- Package transfer_pkg: state enum, KV_OP_NONE/READ/WRITE, KIND_DEBIT/CREDIT, STATUS_* codes, PKT_BYTES.
- Sub-module transfer_pkt_collect: header skip, byte counter, 12-byte packet register, one-cycle pkt_valid; sequencer FSM stays in the top.

## Test plan
- HDR 3 bytes, src 0x00000001, dst 0x00000002, amt 0x00000010; store src 0x100, dst 0x20, zero-wait -> writes src 0xF0 (kind 0), dst 0x30 (kind 1), status OK, done at N+5.
- src balance 0x0F, amt 0x10 -> only RD_SRC issued, status INSUFFICIENT, no writes.
- dst kv_miss on read -> status MISS, no writes; src miss likewise with single read.
- dst 0xFFFFFFF8, amt 0x10 -> status OVERFLOW, no writes; src == dst 0x5 -> one read, status OK.
- Ack delayed 3 cycles per request, bytes offered back-to-back during busy -> outputs stable while waiting, byte_ready low, next packet collected correctly after done.
- rst_n low during WR_DST wait -> next cycle kv_req 0, busy 0, status 0; following full packet processed normally.

Source files
------------

// File: rtl/transfer_pkg.sv
// Shared types and encodings for the transfer sequencer and its packet collector.
package transfer_pkg;

   // Payload length is fixed by the packet format: src key, dst key, amount.
   localparam int PKT_BYTES = 12;

   typedef enum logic [2:0] {
      ST_COLLECT,
      ST_RD_SRC,
      ST_RD_DST,
      ST_WR_SRC,
      ST_WR_DST,
      ST_DONE
   } state_t;

   localparam logic [1:0] KV_OP_NONE  = 2'd0;
   localparam logic [1:0] KV_OP_READ  = 2'd1;
   localparam logic [1:0] KV_OP_WRITE = 2'd2;

   localparam logic KIND_DEBIT  = 1'b0;
   localparam logic KIND_CREDIT = 1'b1;

   localparam logic [1:0] STATUS_OK           = 2'd0;
   localparam logic [1:0] STATUS_INSUFFICIENT = 2'd1;
   localparam logic [1:0] STATUS_MISS         = 2'd2;
   localparam logic [1:0] STATUS_OVERFLOW     = 2'd3;

   // True when a + b does not fit in 32 bits (carry out of a 33-bit sum).
   function automatic logic add_carries(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32];
   endfunction

endpackage

// File: rtl/transfer_pkt_collect.sv
// Byte collector: drops the header bytes, shifts the 12 payload bytes in
// big-endian order and strobes o_pkt_valid on the last payload byte.
module transfer_pkt_collect
   import transfer_pkg::*;
#(
   parameter int HDR_BYTES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_valid,
   input  logic        i_accept,
   output logic        o_pkt_valid,
   output logic [31:0] o_src_key,
   output logic [31:0] o_dst_key,
   output logic [31:0] o_amount
);

   localparam int               CNT_W  = $clog2(HDR_BYTES + PKT_BYTES);
   localparam logic [CNT_W-1:0] C_HDR  = CNT_W'(HDR_BYTES);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HDR_BYTES + PKT_BYTES - 1);

   logic [CNT_W-1:0]       r_cnt;
   logic [PKT_BYTES*8-1:0] r_pkt;
   logic                   w_xfer;

   assign w_xfer = i_byte_valid && i_accept;

   // Strobe coincides with the edge that shifts in the last byte, so the
   // packet register is complete from the following cycle on.
   assign o_pkt_valid = w_xfer && (r_cnt == C_LAST);

   assign o_src_key = r_pkt[95:64];
   assign o_dst_key = r_pkt[63:32];
   assign o_amount  = r_pkt[31:0];

   // Byte position counter across header and payload; wraps after the last byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_xfer) begin
         r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   // Payload shift register; exactly 12 shifts per packet leave byte 0 at the top.
   always_ff @(posedge clk) begin
      if (w_xfer && (r_cnt >= C_HDR)) begin
         r_pkt <= {r_pkt[PKT_BYTES*8-9:0], i_byte};
      end
   end

endmodule

// File: rtl/transfer_sequencer.sv
// Transfer sequencer: collects a packet, then drives the KV store through
// read-source, read-destination, write-debit, write-credit and reports status.
module transfer_sequencer
   import transfer_pkg::*;
#(
   parameter int HDR_BYTES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        kv_req,
   output logic [1:0]  kv_op,
   output logic        kv_kind,
   output logic [31:0] kv_key,
   output logic [31:0] kv_value,
   input  logic        kv_ack,
   input  logic [31:0] kv_rdata,
   input  logic        kv_miss,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status
);

   state_t      r_state;
   logic        r_done;
   logic [1:0]  r_status;
   logic [31:0] r_src_bal;
   logic [31:0] r_dst_bal;

   logic        w_collect;
   logic        w_pkt_valid;
   logic [31:0] w_src_key;
   logic [31:0] w_dst_key;
   logic [31:0] w_amount;

   logic        w_kv_req;
   logic [1:0]  w_kv_op;
   logic        w_kv_kind;
   logic [31:0] w_kv_key;
   logic [31:0] w_kv_value;

   assign w_collect  = (r_state == ST_COLLECT);
   assign byte_ready = w_collect;
   assign busy       = !w_collect;
   assign done       = r_done;
   assign status     = r_status;

   assign kv_req   = w_kv_req;
   assign kv_op    = w_kv_op;
   assign kv_kind  = w_kv_kind;
   assign kv_key   = w_kv_key;
   assign kv_value = w_kv_value;

   transfer_pkt_collect #(
      .HDR_BYTES (HDR_BYTES)
   ) u_collect (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_byte       (byte_in),
      .i_byte_valid (byte_valid),
      .i_accept     (w_collect),
      .o_pkt_valid  (w_pkt_valid),
      .o_src_key    (w_src_key),
      .o_dst_key    (w_dst_key),
      .o_amount     (w_amount)
   );

   // Sequencer: state, done pulse and status all change on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_COLLECT;
         r_done   <= 1'b0;
         r_status <= STATUS_OK;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_COLLECT: begin
               if (w_pkt_valid) r_state <= ST_RD_SRC;
            end
            ST_RD_SRC: begin
               if (kv_ack) begin
                  if (kv_miss) begin
                     r_state  <= ST_DONE;
                     r_done   <= 1'b1;
                     r_status <= STATUS_MISS;
                  end else if (kv_rdata < w_amount) begin
                     r_state  <= ST_DONE;
                     r_done   <= 1'b1;
                     r_status <= STATUS_INSUFFICIENT;
                  end else if (w_src_key == w_dst_key) begin
                     // Self-transfer leaves the balance unchanged; skip the writes.
                     r_state  <= ST_DONE;
                     r_done   <= 1'b1;
                     r_status <= STATUS_OK;
                  end else begin
                     r_state <= ST_RD_DST;
                  end
               end
            end
            ST_RD_DST: begin
               if (kv_ack) begin
                  if (kv_miss) begin
                     r_state  <= ST_DONE;
                     r_done   <= 1'b1;
                     r_status <= STATUS_MISS;
                  end else if (add_carries(kv_rdata, w_amount)) begin
                     r_state  <= ST_DONE;
                     r_done   <= 1'b1;
                     r_status <= STATUS_OVERFLOW;
                  end else begin
                     r_state <= ST_WR_SRC;
                  end
               end
            end
            ST_WR_SRC: begin
               if (kv_ack) r_state <= ST_WR_DST;
            end
            ST_WR_DST: begin
               if (kv_ack) begin
                  r_state  <= ST_DONE;
                  r_done   <= 1'b1;
                  r_status <= STATUS_OK;
               end
            end
            ST_DONE: begin
               r_state <= ST_COLLECT;
            end
            default: begin
               r_state <= ST_COLLECT;
            end
         endcase
      end
   end

   // Balance capture on read acknowledge; only consumed after the checks pass.
   always_ff @(posedge clk) begin
      if (kv_ack && (r_state == ST_RD_SRC)) r_src_bal <= kv_rdata;
      if (kv_ack && (r_state == ST_RD_DST)) r_dst_bal <= kv_rdata;
   end

   // Store port decode: Moore outputs from state and registered packet/balances.
   always_comb begin
      w_kv_req   = 1'b0;
      w_kv_op    = KV_OP_NONE;
      w_kv_kind  = KIND_DEBIT;
      w_kv_key   = '0;
      w_kv_value = '0;
      case (r_state)
         ST_RD_SRC: begin
            w_kv_req  = 1'b1;
            w_kv_op   = KV_OP_READ;
            w_kv_kind = KIND_DEBIT;
            w_kv_key  = w_src_key;
         end
         ST_RD_DST: begin
            w_kv_req  = 1'b1;
            w_kv_op   = KV_OP_READ;
            w_kv_kind = KIND_CREDIT;
            w_kv_key  = w_dst_key;
         end
         ST_WR_SRC: begin
            w_kv_req   = 1'b1;
            w_kv_op    = KV_OP_WRITE;
            w_kv_kind  = KIND_DEBIT;
            w_kv_key   = w_src_key;
            w_kv_value = r_src_bal - w_amount;
         end
         ST_WR_DST: begin
            w_kv_req   = 1'b1;
            w_kv_op    = KV_OP_WRITE;
            w_kv_kind  = KIND_CREDIT;
            w_kv_key   = w_dst_key;
            w_kv_value = r_dst_bal + w_amount;
         end
         default: begin
         end
      endcase
   end

endmodule
